// File: rtl/fwd_scoreboard_pkg.sv
// fwd_scoreboard_pkg
//   Shared definitions for the operand-forwarding / load-use hazard unit.
//   - Default parameter values for the LC-3b datapath configuration.
//   - fwd_entry_t: in-flight destination tag at the default register width.
//     The decoder side uses this view. The scoreboard itself keeps a
//     REG_W-parametrised copy of the same layout.
//   - sat_inc16: saturating 16-bit event counter step.
package fwd_scoreboard_pkg;

    localparam int FWD_DATA_W_DEF     = 16;
    localparam int FWD_REG_W_DEF      = 3;
    localparam int FWD_DEPTH_DEF      = 3;
    localparam int FWD_NUM_SRC_DEF    = 2;
    localparam int FWD_KILL_DEPTH_DEF = 1;

    localparam logic [15:0] FWD_CNT_MAX = 16'hFFFF;

    typedef struct packed {
        logic                     v;
        logic [FWD_REG_W_DEF-1:0] dest;
    } fwd_entry_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt, input logic en);
        return (en && (cnt != FWD_CNT_MAX)) ? cnt + 16'd1 : cnt;
    endfunction

endpackage

// File: rtl/fwd_scoreboard_lookup.sv
// fwd_lookup
//   Combinational priority match for one source operand against the
//   in-flight destination tags. The lowest-index (youngest) valid match
//   decides the result, even when that producer's data is not yet final.
// Ports:
//   ent_v / ent_dest      valid bits and destination tags, index 0 = youngest
//   stage_data / _ok      per-stage result values and their final flags
//   sel / used            source register and whether it is actually read
//   rf_data               register-file value, used when nothing forwards
//   data / hit / pending  operand, served-from-stage flag, youngest match not ready
module fwd_lookup
    import fwd_scoreboard_pkg::*;
#(
    parameter int DATA_W = FWD_DATA_W_DEF,
    parameter int REG_W  = FWD_REG_W_DEF,
    parameter int DEPTH  = FWD_DEPTH_DEF
) (
    input  logic [DEPTH-1:0]        ent_v,
    input  logic [DEPTH*REG_W-1:0]  ent_dest,
    input  logic [DEPTH*DATA_W-1:0] stage_data,
    input  logic [DEPTH-1:0]        stage_data_ok,
    input  logic [REG_W-1:0]        sel,
    input  logic                    used,
    input  logic [DATA_W-1:0]       rf_data,
    output logic [DATA_W-1:0]       data,
    output logic                    hit,
    output logic                    pending
);

    logic found;

    always_comb begin
        data    = rf_data;
        hit     = 1'b0;
        pending = 1'b0;
        found   = 1'b0;
        // The first match in index order stops the search, so an older
        // ready producer never overrides a younger one that is still pending.
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && used && ent_v[i] && (ent_dest[i*REG_W +: REG_W] == sel)) begin
                found = 1'b1;
                if (stage_data_ok[i]) begin
                    data = stage_data[i*DATA_W +: DATA_W];
                    hit  = 1'b1;
                end else begin
                    pending = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard
//   Operand-forwarding and load-use hazard unit between the ID/EX latch and
//   the ALU/address-gen inputs. It tracks the destination tags of the
//   instructions in the DEPTH stages after EX, forwards the youngest ready
//   producer to each source operand, and stalls when the youngest producer
//   has not finished yet.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   adv                    pipeline advances (0 = hold all entries)
//   flush                  redirect; entries 0..KILL_DEPTH-1 are killed
//   issue_valid/_wr/_dest  instruction currently in ID/EX
//   stage_data, stage_data_ok  per-stage results and their final flags
//   src_sel, src_used, src_rf_data  source lookups and register-file values
//   src_data, fwd_hit      forwarded operands, per-source forward flags
//   hazard_stall           hold ID/EX and upstream, bubble into stage 0
//   stall_cnt, fwd_cnt     saturating event counters
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int DATA_W     = FWD_DATA_W_DEF,
    parameter int REG_W      = FWD_REG_W_DEF,
    parameter int DEPTH      = FWD_DEPTH_DEF,
    parameter int NUM_SRC    = FWD_NUM_SRC_DEF,
    parameter int KILL_DEPTH = FWD_KILL_DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      adv,
    input  logic                      flush,
    input  logic                      issue_valid,
    input  logic                      issue_wr,
    input  logic [REG_W-1:0]          issue_dest,
    input  logic [DEPTH*DATA_W-1:0]   stage_data,
    input  logic [DEPTH-1:0]          stage_data_ok,
    input  logic [NUM_SRC*REG_W-1:0]  src_sel,
    input  logic [NUM_SRC-1:0]        src_used,
    input  logic [NUM_SRC*DATA_W-1:0] src_rf_data,
    output logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic                      hazard_stall,
    output logic [NUM_SRC-1:0]        fwd_hit,
    output logic [15:0]               stall_cnt,
    output logic [15:0]               fwd_cnt
);

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] dest;
    } entry_t;

    entry_t ent_q [DEPTH];
    entry_t ent_d [DEPTH];

    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] fwd_cnt_q, fwd_cnt_d;

    logic [DEPTH-1:0]       ent_v;
    logic [DEPTH*REG_W-1:0] ent_dest;
    logic [NUM_SRC-1:0]     pending;

    always_comb begin
        ent_v    = '0;
        ent_dest = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_v[i]                    = ent_q[i].v;
            ent_dest[i*REG_W +: REG_W]  = ent_q[i].dest;
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        fwd_lookup #(
            .DATA_W (DATA_W),
            .REG_W  (REG_W),
            .DEPTH  (DEPTH)
        ) u_lookup (
            .ent_v         (ent_v),
            .ent_dest      (ent_dest),
            .stage_data    (stage_data),
            .stage_data_ok (stage_data_ok),
            .sel           (src_sel[g*REG_W +: REG_W]),
            .used          (src_used[g]),
            .rf_data       (src_rf_data[g*DATA_W +: DATA_W]),
            .data          (src_data[g*DATA_W +: DATA_W]),
            .hit           (fwd_hit[g]),
            .pending       (pending[g])
        );
    end

    assign hazard_stall = issue_valid & (|pending);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
        end
        if (adv) begin
            for (int i = 1; i < DEPTH; i++) begin
                ent_d[i] = ent_q[i-1];
            end
            // A stalled instruction stays in ID/EX, so stage 0 gets a bubble.
            ent_d[0].v    = issue_valid & issue_wr & ~hazard_stall & ~flush;
            ent_d[0].dest = issue_dest;
        end
        // Applied after the shift, so with adv=1 the killed window covers
        // the younger instructions that moved in this edge.
        if (flush) begin
            for (int i = 0; i < KILL_DEPTH; i++) begin
                ent_d[i].v = 1'b0;
            end
        end
    end

    assign stall_cnt_d = sat_inc16(stall_cnt_q, hazard_stall);
    assign fwd_cnt_d   = sat_inc16(fwd_cnt_q, |fwd_hit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
module tb_fwd_scoreboard;

    localparam int DW = 16;
    localparam int RW = 3;
    localparam int D  = 3;
    localparam int NS = 2;
    localparam int KD = 1;

    logic              clk;
    logic              reset_n;
    logic              adv;
    logic              flush;
    logic              issue_valid;
    logic              issue_wr;
    logic [RW-1:0]     issue_dest;
    logic [D*DW-1:0]   stage_data;
    logic [D-1:0]      stage_data_ok;
    logic [NS*RW-1:0]  src_sel;
    logic [NS-1:0]     src_used;
    logic [NS*DW-1:0]  src_rf_data;
    logic [NS*DW-1:0]  src_data;
    logic              hazard_stall;
    logic [NS-1:0]     fwd_hit;
    logic [15:0]       stall_cnt;
    logic [15:0]       fwd_cnt;

    fwd_scoreboard #(
        .DATA_W(DW), .REG_W(RW), .DEPTH(D), .NUM_SRC(NS), .KILL_DEPTH(KD)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .adv           (adv),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_wr      (issue_wr),
        .issue_dest    (issue_dest),
        .stage_data    (stage_data),
        .stage_data_ok (stage_data_ok),
        .src_sel       (src_sel),
        .src_used      (src_used),
        .src_rf_data   (src_rf_data),
        .src_data      (src_data),
        .hazard_stall  (hazard_stall),
        .fwd_hit       (fwd_hit),
        .stall_cnt     (stall_cnt),
        .fwd_cnt       (fwd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // In-flight instructions as a queue, front = youngest.
    typedef struct {
        bit v;
        int dest;
    } ment_t;

    typedef struct {
        logic [NS*DW-1:0] data;
        logic [NS-1:0]    hit;
        logic             stall;
        logic [15:0]      sc;
        logic [15:0]      fc;
    } exp_t;

    ment_t pipe[$];
    int    m_scnt;
    int    m_fcnt;
    bit    cur_stall;
    bit    cur_fwd;
    exp_t  exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    function automatic void model_clear();
        ment_t z;
        z.v = 0;
        z.dest = 0;
        pipe.delete();
        for (int i = 0; i < D; i++) pipe.push_back(z);
        m_scnt = 0;
        m_fcnt = 0;
    endfunction

    function automatic void model_eval(output exp_t e);
        bit any_pend;
        any_pend = 0;
        if (!reset_n) model_clear();
        e.data = src_rf_data;
        e.hit  = '0;
        for (int j = 0; j < NS; j++) begin
            if (src_used[j]) begin
                for (int i = 0; i < D; i++) begin
                    if (pipe[i].v && pipe[i].dest == int'(src_sel[j*RW +: RW])) begin
                        if (stage_data_ok[i]) begin
                            e.data[j*DW +: DW] = stage_data[i*DW +: DW];
                            e.hit[j] = 1'b1;
                        end else begin
                            any_pend = 1;
                        end
                        break;
                    end
                end
            end
        end
        e.stall   = issue_valid && any_pend;
        e.sc      = 16'(m_scnt);
        e.fc      = 16'(m_fcnt);
        cur_stall = e.stall;
        cur_fwd   = (e.hit != '0);
    endfunction

    function automatic void model_update();
        ment_t n;
        if (!reset_n) begin
            model_clear();
            return;
        end
        if (adv) begin
            n.v    = issue_valid && issue_wr && !cur_stall && !flush;
            n.dest = int'(issue_dest);
            pipe.push_front(n);
            void'(pipe.pop_back());
        end
        if (flush) for (int i = 0; i < KD; i++) pipe[i].v = 0;
        if (cur_stall && m_scnt < 65535) m_scnt++;
        if (cur_fwd && m_fcnt < 65535) m_fcnt++;
    endfunction

    // ---------------- monitor ----------------
    exp_t m_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            n_vec++;
            if (src_data !== m_e.data || fwd_hit !== m_e.hit || hazard_stall !== m_e.stall ||
                stall_cnt !== m_e.sc || fwd_cnt !== m_e.fc) begin
                n_err++;
                $display("FAIL scoreboard t=%0t got data=%h hit=%b stall=%b scnt=%0d fcnt=%0d expected data=%h hit=%b stall=%b scnt=%0d fcnt=%0d",
                         $time, src_data, fwd_hit, hazard_stall, stall_cnt, fwd_cnt,
                         m_e.data, m_e.hit, m_e.stall, m_e.sc, m_e.fc);
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs are already applied; push the expectation and wait for the sample point.
    task automatic cyc();
        exp_t e;
        model_eval(e);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic adv_edge();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        adv           = 1'b1;
        flush         = 1'b0;
        issue_valid   = 1'b0;
        issue_wr      = 1'b0;
        issue_dest    = '0;
        stage_data    = '0;
        stage_data_ok = '1;
        src_sel       = '0;
        src_used      = '0;
        src_rf_data   = {16'h2222, 16'h1111};
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        cyc();
        adv_edge();
        reset_n = 1'b1;
    endtask

    task automatic issue_wr_dest(input logic [RW-1:0] d);
        issue_valid = 1'b1;
        issue_wr    = 1'b1;
        issue_dest  = d;
        adv         = 1'b1;
        cyc();
        adv_edge();
        issue_valid = 1'b0;
        issue_wr    = 1'b0;
    endtask

    initial begin
        model_clear();
        cur_stall = 0;
        cur_fwd   = 0;
        reset_n   = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;

        // Reset: pass-through
        src_sel  = {3'd0, 3'd3};
        src_used = 2'b11;
        cyc();
        chk("rst_data", 32'(src_data[15:0]), 32'h1111);
        chk("rst_hit", 32'(fwd_hit), 32'h0);
        chk("rst_stall", 32'(hazard_stall), 32'h0);
        adv_edge();
        reset_n = 1'b1;

        // ADD R3 then forward from stage 0
        do_reset();
        issue_wr_dest(3'd3);
        src_sel    = {3'd0, 3'd3};
        src_used   = 2'b01;
        stage_data = {16'h0, 16'h0, 16'h00AB};
        cyc();
        chk("add_data", 32'(src_data[15:0]), 32'h00AB);
        chk("add_hit", 32'(fwd_hit), 32'h1);
        chk("add_stall", 32'(hazard_stall), 32'h0);
        adv_edge();
        src_used = 2'b00;
        cyc();
        chk("add_fwd_cnt", 32'(fwd_cnt), 32'h1);
        adv_edge();

        // Two producers for R5: youngest wins, and its pending state blocks the older one
        do_reset();
        issue_wr_dest(3'd5);
        issue_wr_dest(3'd5);
        adv        = 1'b0;
        src_sel    = {3'd0, 3'd5};
        src_used   = 2'b01;
        stage_data = {16'h3333, 16'hBBBB, 16'hAAAA};
        cyc();
        chk("young_data", 32'(src_data[15:0]), 32'hAAAA);
        adv_edge();
        stage_data_ok = 3'b110;
        issue_valid   = 1'b1;
        cyc();
        chk("young_pend_stall", 32'(hazard_stall), 32'h1);
        chk("young_pend_hit", 32'(fwd_hit), 32'h0);
        chk("young_pend_data", 32'(src_data[15:0]), 32'h1111);
        adv_edge();

        // Load-use: one stall cycle, then forward from stage 1
        do_reset();
        issue_wr_dest(3'd2);
        issue_valid   = 1'b1;
        issue_wr      = 1'b1;
        issue_dest    = 3'd6;
        src_sel       = {3'd0, 3'd2};
        src_used      = 2'b01;
        stage_data    = {16'h0, 16'h1234, 16'h0};
        stage_data_ok = 3'b110;
        cyc();
        chk("ld_stall", 32'(hazard_stall), 32'h1);
        adv_edge();
        stage_data_ok = 3'b111;
        cyc();
        chk("ld_fwd_stall", 32'(hazard_stall), 32'h0);
        chk("ld_fwd_data", 32'(src_data[15:0]), 32'h1234);
        chk("ld_fwd_hit", 32'(fwd_hit), 32'h1);
        chk("ld_stall_cnt", 32'(stall_cnt), 32'h1);
        adv_edge();

        // Global memory stall for 4 cycles with a pending load
        do_reset();
        issue_wr_dest(3'd2);
        issue_valid   = 1'b1;
        issue_wr      = 1'b1;
        issue_dest    = 3'd6;
        src_sel       = {3'd0, 3'd2};
        src_used      = 2'b01;
        stage_data    = {16'h0, 16'h0, 16'h5678};
        stage_data_ok = 3'b000;
        adv           = 1'b0;
        repeat (4) begin
            cyc();
            chk("frz_stall", 32'(hazard_stall), 32'h1);
            adv_edge();
        end
        adv           = 1'b1;
        stage_data_ok = 3'b111;
        cyc();
        chk("frz_stall_cnt", 32'(stall_cnt), 32'h4);
        chk("frz_data", 32'(src_data[15:0]), 32'h5678);
        chk("frz_release", 32'(hazard_stall), 32'h0);
        adv_edge();

        // Flush with adv=1: entry 0 killed after the shift
        do_reset();
        issue_wr_dest(3'd4);
        issue_wr_dest(3'd4);
        flush = 1'b1;
        cyc();
        adv_edge();
        flush      = 1'b0;
        src_sel    = {3'd0, 3'd4};
        src_used   = 2'b01;
        stage_data = {16'h3000, 16'h2000, 16'h1000};
        cyc();
        chk("flush_data", 32'(src_data[15:0]), 32'h2000);
        chk("flush_hit", 32'(fwd_hit), 32'h1);
        adv_edge();

        // Flush with adv=0: entry 0 cleared in place
        do_reset();
        issue_wr_dest(3'd4);
        flush = 1'b1;
        adv   = 1'b0;
        cyc();
        adv_edge();
        flush    = 1'b0;
        src_sel  = {3'd0, 3'd4};
        src_used = 2'b01;
        cyc();
        chk("flush_hold_hit", 32'(fwd_hit), 32'h0);
        chk("flush_hold_data", 32'(src_data[15:0]), 32'h1111);
        adv_edge();

        // Mid-stream asynchronous reset
        do_reset();
        issue_wr_dest(3'd7);
        src_sel    = {3'd0, 3'd7};
        src_used   = 2'b01;
        stage_data = {16'h0, 16'h7777, 16'h7777};
        cyc();
        adv_edge();
        reset_n = 1'b0;
        cyc();
        chk("async_rst_fcnt", 32'(fwd_cnt), 32'h0);
        chk("async_rst_hit", 32'(fwd_hit), 32'h0);
        chk("async_rst_data", 32'(src_data[15:0]), 32'h1111);
        adv_edge();
        reset_n = 1'b1;

        // Randomized traffic
        repeat (3000) begin
            reset_n       = ($urandom_range(0, 299) != 0);
            adv           = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 9) == 0);
            issue_valid   = ($urandom_range(0, 3) != 0);
            issue_wr      = ($urandom_range(0, 2) != 0);
            issue_dest    = RW'($urandom_range(0, 7));
            src_sel       = (NS*RW)'($urandom);
            src_used      = NS'($urandom);
            src_rf_data   = (NS*DW)'($urandom);
            stage_data    = {16'($urandom), 32'($urandom)};
            stage_data_ok = D'($urandom);
            cyc();
            adv_edge();
        end

        reset_n = 1'b1;
        idle();
        cyc();
        adv_edge();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
